// File: rtl/wb_lfsr_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_lfsr_pkg
// Brief    : Register map and CTRL bit positions for the wb_lfsr_multi slave.
// Revision : 1.0 - initial release
// ============================================================================
package wb_lfsr_pkg;

  localparam logic [5:0] ADDR_SEED   = 6'h00;
  localparam logic [5:0] ADDR_TAPS   = 6'h10;
  localparam logic [5:0] ADDR_CTRL   = 6'h20;
  localparam logic [5:0] ADDR_OUT    = 6'h21;
  localparam logic [5:0] ADDR_CNT_LO = 6'h22;
  localparam logic [5:0] ADDR_CNT_HI = 6'h23;
  localparam logic [5:0] ADDR_STAT   = 6'h24;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_SOR  = 1;
  localparam int CTRL_LOAD = 2;
  localparam int CTRL_STEP = 3;

endpackage
`default_nettype wire

// File: rtl/wb_lfsr_multi_step.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_step_n
// Brief    : Combinational Fibonacci LFSR advance by N steps, unrolled.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_step_n #(
  parameter int WIDTH = 32,
  parameter int N     = 1
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] w_chain [0:N];

  assign w_chain[0] = i_state;

  for (genvar g = 0; g < N; g++) begin : g_step
    assign w_chain[g+1] = {w_chain[g][WIDTH-2:0], ^(w_chain[g] & i_taps)};
  end

  assign o_state = w_chain[N];

endmodule
`default_nettype wire

// File: rtl/wb_lfsr_multi.sv
`default_nettype none
// ============================================================================
// Module   : wb_lfsr_multi
// Brief    : 8-bit Wishbone slave LFSR with programmable seed/taps, run,
//            single-step and step-on-read modes and a 16-bit step counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_lfsr_multi
  import wb_lfsr_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] TAPS_RST       = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0] SEED_RST       = WIDTH'(1),
  parameter int               STEPS_PER_READ = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [5:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_stall,
  output logic       o_wb_ack,
  output logic [7:0] o_wb_data
);

  localparam int          NBYTES = WIDTH / 8;
  localparam logic [15:0] C_SPR  = 16'(STEPS_PER_READ);

  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_taps;
  logic [WIDTH-1:0] r_state;
  logic             r_run;
  logic             r_sor;
  logic [15:0]      r_count;
  logic             r_ack;
  logic [7:0]       r_rdata;

  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  logic             w_ctrl_wr;
  logic             w_load;
  logic             w_step;
  logic             w_sor_rd;
  logic             w_zero;
  logic [7:0]       w_rdata;
  logic [WIDTH-1:0] w_next_1;
  logic [WIDTH-1:0] w_next_n;

  assign w_acc     = i_wb_cyc & i_wb_stb;
  assign w_wr      = w_acc & i_wb_we;
  assign w_rd      = w_acc & ~i_wb_we;
  assign w_ctrl_wr = w_wr && (i_wb_addr == ADDR_CTRL);
  assign w_load    = w_ctrl_wr & i_wb_data[CTRL_LOAD];
  assign w_step    = w_ctrl_wr & i_wb_data[CTRL_STEP];
  assign w_sor_rd  = w_rd && (i_wb_addr == ADDR_OUT) && r_sor;
  assign w_zero    = (r_state == '0);

  lfsr_step_n #(.WIDTH(WIDTH), .N(1)) u_step_1 (
    .i_state (r_state),
    .i_taps  (r_taps),
    .o_state (w_next_1)
  );

  lfsr_step_n #(.WIDTH(WIDTH), .N(STEPS_PER_READ)) u_step_n (
    .i_state (r_state),
    .i_taps  (r_taps),
    .o_state (w_next_n)
  );

  // Byte-addressed seed/taps; addresses past NBYTES never match.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seed <= SEED_RST;
      r_taps <= TAPS_RST;
      r_run  <= 1'b0;
      r_sor  <= 1'b0;
    end else if (w_wr) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_wb_addr == 6'(ADDR_SEED + 6'(k))) r_seed[8*k +: 8] <= i_wb_data;
        if (i_wb_addr == 6'(ADDR_TAPS + 6'(k))) r_taps[8*k +: 8] <= i_wb_data;
      end
      if (w_ctrl_wr) begin
        r_run <= i_wb_data[CTRL_RUN];
        r_sor <= i_wb_data[CTRL_SOR];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SEED_RST;
      r_count <= 16'h0000;
    end else if (w_load) begin
      r_state <= r_seed;
      r_count <= 16'h0000;
    end else if (w_sor_rd) begin
      r_state <= w_next_n;
      r_count <= r_count + C_SPR;
    end else if (w_step || r_run) begin
      r_state <= w_next_1;
      r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (i_wb_addr == 6'(ADDR_SEED + 6'(k))) w_rdata = r_seed[8*k +: 8];
      if (i_wb_addr == 6'(ADDR_TAPS + 6'(k))) w_rdata = r_taps[8*k +: 8];
    end
    case (i_wb_addr)
      ADDR_CTRL:   w_rdata = {6'b0, r_sor, r_run};
      ADDR_OUT:    w_rdata = r_state[7:0];
      ADDR_CNT_LO: w_rdata = r_count[7:0];
      ADDR_CNT_HI: w_rdata = r_count[15:8];
      ADDR_STAT:   w_rdata = {6'b0, r_run, w_zero};
      default:     ;
    endcase
  end

  // Read data reflects pre-step state because it samples the comb mux.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = r_ack;
  assign o_wb_data  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_lfsr_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_lfsr_multi
// Brief    : Directed + randomized bench for wb_lfsr_multi (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_lfsr_multi;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wb_cyc = 1'b0;
  logic       i_wb_stb = 1'b0;
  logic       i_wb_we = 1'b0;
  logic [5:0] i_wb_addr = 6'h00;
  logic [7:0] i_wb_data = 8'h00;
  logic       o_wb_stall;
  logic       o_wb_ack;
  logic [7:0] o_wb_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_seed, m_taps, m_state;
  logic        m_run, m_sor;
  logic [15:0] m_cnt;

  wb_lfsr_multi #(
    .WIDTH          (8),
    .TAPS_RST       (8'hB8),
    .SEED_RST       (8'h01),
    .STEPS_PER_READ (8)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_data  (o_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input logic [7:0] t, input int n);
    int fb;
    for (int i = 0; i < n; i++) begin
      fb = $countones(s & t) % 2;
      s = 8'((s * 2) + fb);
    end
    return s;
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    case (a)
      6'h00:   return m_seed;
      6'h10:   return m_taps;
      6'h20:   return {6'b0, m_sor, m_run};
      6'h21:   return m_state;
      6'h22:   return m_cnt[7:0];
      6'h23:   return m_cnt[15:8];
      6'h24:   return {6'b0, m_run, (m_state == 8'h00)};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_update(input logic rst, input logic acc, input logic we,
                          input logic [5:0] a, input logic [7:0] d);
    logic wr, ld, st, sr;
    if (rst) begin
      m_seed = 8'h01; m_taps = 8'hB8; m_state = 8'h01;
      m_run = 1'b0; m_sor = 1'b0; m_cnt = 16'h0000;
      return;
    end
    wr = acc & we;
    ld = wr && (a == 6'h20) && d[2];
    st = wr && (a == 6'h20) && d[3];
    sr = acc && !we && (a == 6'h21) && m_sor;
    if (ld) begin
      m_state = m_seed; m_cnt = 16'h0000;
    end else if (sr) begin
      m_state = lfsr_adv(m_state, m_taps, 8); m_cnt = m_cnt + 16'd8;
    end else if (st || m_run) begin
      m_state = lfsr_adv(m_state, m_taps, 1); m_cnt = m_cnt + 16'd1;
    end
    if (wr) begin
      if (a == 6'h00) m_seed = d;
      if (a == 6'h10) m_taps = d;
      if (a == 6'h20) begin m_run = d[0]; m_sor = d[1]; end
    end
  endtask

  // One bus cycle: drive, clock, update model, check ack and read data.
  task automatic bus(input logic rst, input logic acc, input logic we,
                     input logic [5:0] a, input logic [7:0] d, output logic [7:0] rd);
    logic [7:0] exp;
    i_reset = rst; i_wb_cyc = acc; i_wb_stb = acc; i_wb_we = we;
    i_wb_addr = a; i_wb_data = d;
    exp = m_read(a);
    @(posedge i_clk);
    m_update(rst, acc, we, a, d);
    #1;
    chk("ack", 16'(o_wb_ack), 16'(acc && !rst));
    rd = o_wb_data;
    if (acc && !we && !rst) chk($sformatf("read_%02h", a), 16'(o_wb_data), 16'(exp));
    i_reset = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic do_reset();
    logic [7:0] rd;
    bus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, rd);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] rd;
    bus(1'b0, 1'b1, 1'b1, a, d, rd);
  endtask

  task automatic rdr(input logic [5:0] a, output logic [7:0] rd);
    bus(1'b0, 1'b1, 1'b0, a, 8'h00, rd);
  endtask

  task automatic idle(input int n);
    logic [7:0] rd;
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, rd);
  endtask

  initial begin
    logic [7:0] rd;
    logic [5:0] addrs [12];
    logic [5:0] a;
    logic [7:0] d;
    int r;
    addrs = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h20, 6'h20, 6'h21, 6'h21,
              6'h22, 6'h23, 6'h24, 6'h30};

    @(posedge i_clk); #1;
    do_reset();
    chk("stall", 16'(o_wb_stall), 16'h0);
    chk("rst_ack", 16'(o_wb_ack), 16'h0);
    chk("rst_data", 16'(o_wb_data), 16'h00);

    rdr(6'h21, rd); chk("rst_out", 16'(rd), 16'h01);
    idle(1);
    chk("ack_one_cycle", 16'(o_wb_ack), 16'h0);
    rdr(6'h20, rd); chk("rst_ctrl", 16'(rd), 16'h00);
    rdr(6'h22, rd); chk("rst_cnt_lo", 16'(rd), 16'h00);
    rdr(6'h23, rd); chk("rst_cnt_hi", 16'(rd), 16'h00);

    for (int i = 0; i < 4; i++) wr(6'h20, 8'h08);
    rdr(6'h21, rd); chk("step4_out", 16'(rd), 16'h11);
    rdr(6'h22, rd); chk("step4_cnt", 16'(rd), 16'h04);

    do_reset();
    wr(6'h20, 8'h02);
    rdr(6'h21, rd); chk("sor_out0", 16'(rd), 16'h01);
    rdr(6'h21, rd); chk("sor_out1", 16'(rd), 16'h1C);
    rdr(6'h22, rd); chk("sor_cnt", 16'(rd), 16'h10);

    do_reset();
    wr(6'h00, 8'hA5);
    wr(6'h20, 8'h04);
    rdr(6'h21, rd); chk("load_out", 16'(rd), 16'hA5);
    rdr(6'h22, rd); chk("load_cnt", 16'(rd), 16'h00);
    rdr(6'h20, rd); chk("load_ctrl", 16'(rd), 16'h00);

    do_reset();
    wr(6'h00, 8'h00);
    wr(6'h20, 8'h05);
    idle(10);
    rdr(6'h22, rd); chk("zero_cnt", 16'(rd), 16'h0A);
    rdr(6'h24, rd); chk("zero_stat", 16'(rd), 16'h03);
    rdr(6'h21, rd); chk("zero_out", 16'(rd), 16'h00);

    do_reset();
    wr(6'h01, 8'h55);
    wr(6'h30, 8'hAA);
    rdr(6'h01, rd); chk("unmap_01", 16'(rd), 16'h00);
    rdr(6'h30, rd); chk("unmap_30", 16'(rd), 16'h00);
    rdr(6'h00, rd); chk("seed_kept", 16'(rd), 16'h01);
    wr(6'h20, 8'h01);
    idle(5);
    bus(1'b1, 1'b1, 1'b0, 6'h21, 8'h00, rd);
    chk("rst_drop_ack", 16'(o_wb_ack), 16'h0);
    rdr(6'h21, rd); chk("rst_mid_out", 16'(rd), 16'h01);
    rdr(6'h22, rd); chk("rst_mid_cnt", 16'(rd), 16'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      a = addrs[$urandom_range(0, 11)];
      d = 8'($urandom);
      if (a == 6'h20) d = {4'b0, d[3:0]};
      if (r < 2)       bus(1'b1, 1'($urandom_range(0, 1)), 1'b0, a, d, rd);
      else if (r < 25) idle(1);
      else if (r < 55) wr(a, d);
      else             rdr(a, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_lfsr_multi.md
Name: wb_lfsr_multi

Overview:
Wishbone-slave LFSR peripheral with run-time programmable width-parametrised seed and tap mask. It supports free-running, single-step and step-on-read modes, plus a step counter and a zero-lockup flag. The CPU reads a fresh byte of pseudo-random state per access. It is the parametrised successor of the fixed 32-bit single-bit-output LFSR slave and sits on the same 8-bit Wishbone peripheral bus.

Parameters:
WIDTH, 32, LFSR state width in bits; multiple of 8, range 8..64; NBYTES = WIDTH/8
TAPS_RST, 32'h80200003, tap mask loaded at reset; width WIDTH
SEED_RST, 1, seed and state value at reset; must be non-zero
STEPS_PER_READ, 8, LFSR steps applied after each OUT read in step-on-read mode; range 1..8

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  6  register address
i_wb_data  in  8  write data
o_wb_stall  out  1  tied 0
o_wb_ack  out  1  one-cycle acknowledge
o_wb_data  out  8  registered read data

Behaviour:
- Reset: i_reset and i_clk as above.
  - Values on reset: seed=SEED_RST, taps=TAPS_RST, state=SEED_RST, ctrl=0, count=0, o_wb_ack=0, o_wb_data=0.
- Access: acc = cyc & stb. o_wb_ack = acc, registered, so it rises exactly 1 cycle after the strobe. o_wb_data is valid in the same cycle as ack.
- Register map:
  - 0x00+k, k<NBYTES: SEED byte k, R/W.
  - 0x10+k, k<NBYTES: TAPS byte k, R/W.
  - 0x20 CTRL, R/W:
    - b0 RUN: free-run, 1 step per cycle.
    - b1 SOR: step-on-read.
    - b2 LOAD: write-1 strobe; self-clears and reads as 0.
    - b3 STEP: write-1 strobe for one step; self-clears.
  - 0x21 OUT, RO: state[7:0].
  - 0x22/0x23 COUNT lo/hi, RO: 16-bit step counter; wraps mod 2^16.
  - 0x24 STATUS, RO: b0 ZERO (state==0), b1 RUN.
  - Any other address, including bytes k>=NBYTES: writes ignored, reads return 0x00. Unmapped writes never corrupt seed.
- Step function: next = {state[WIDTH-2:0], ^(state & taps)}. N steps is this function applied N times, unrolled, within 1 cycle.
- Per-cycle priority:
  1. LOAD: state<=seed, count<=0.
  2. SOR read of OUT: STEPS_PER_READ steps.
  3. STEP strobe or RUN: 1 step.
  4. Otherwise hold.
  - Only the highest-priority action happens; count adds the number of steps taken.
- Read/step ordering: an OUT read returns state before the step, i.e. the value at the strobe cycle. The advance is visible from the next cycle.
- Write while running: SEED and TAPS writes affect state only via LOAD; TAPS changes apply from the next step.
- Same-cycle write: a CTRL write with LOAD=1 and RUN=1 loads this cycle and runs from the next cycle.
- Zero lockup: state==0 persists and ZERO=1; count still increments. Loading seed 0 is permitted.
- Reset mid-operation: all state returns to reset values in 1 cycle, and an in-flight ack is dropped.

Decomposition:
- Package wb_lfsr_pkg:
  - address constants: ADDR_SEED=0x00, ADDR_TAPS=0x10, ADDR_CTRL=0x20, ADDR_OUT=0x21, ADDR_CNT_LO=0x22, ADDR_CNT_HI=0x23, ADDR_STAT=0x24.
  - CTRL bit indices.
- Sub-module lfsr_step_n (parameters WIDTH, N): combinational state/taps -> state after N steps. Instantiate it for N=1 and N=STEPS_PER_READ.
- The top module holds the registers, the bus decode and the counter.

Test Plan (WIDTH=8, TAPS_RST=0xB8, SEED_RST=0x01, STEPS_PER_READ=8):
- After reset, read OUT, CTRL and COUNT -> 0x01, 0x00 and 0x0000; each ack arrives exactly 1 cycle after the strobe.
- Write CTRL=0x08 (STEP) four times, then read OUT -> 0x11 (0x01→0x02→0x04→0x08→0x11); COUNT=4.
- Write CTRL=0x02 (SOR), read OUT twice, then read COUNT -> 0x01, then 0x1C; COUNT=16.
- Write SEED=0xA5, then CTRL=0x04 (LOAD) -> OUT=0xA5, COUNT=0; CTRL reads 0x00.
- Write SEED=0x00, LOAD, RUN for 10 cycles -> OUT=0x00, STATUS=0x03, COUNT=10.
- Write to 0x01 and 0x30, then read them and SEED -> writes ignored, reads 0x00, SEED unchanged. Assert i_reset during RUN -> next cycle OUT=0x01, ack=0, COUNT=0.
